// File: rtl/feedback_echo_if.sv
// Sample stream bus for feedback_echo: strobed input sample, registered output sample with valid pulse.
interface feedback_echo_if #(
    parameter int unsigned DATA_BITS = 16
);
    logic                 enable;
    logic [DATA_BITS-1:0] din;
    logic [DATA_BITS-1:0] dout;
    logic                 dout_valid;

    modport master (output enable, din, input dout, dout_valid);
    modport slave  (input enable, din, output dout, dout_valid);
endinterface

// File: rtl/feedback_echo.sv
// Feedback echo: circular delay line with feedback, dry/wet mix, two-stage pipeline.
// Optional macro FEEDBACK_ECHO_SAT_EN selects clamping saturation instead of wrap-around.
module feedback_echo #(
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned COEF_BITS = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    feedback_echo_if.slave       bus,
    input  logic [ADDR_BITS-1:0] delay_len,
    input  logic [COEF_BITS-1:0] fb_gain,
    input  logic [COEF_BITS-1:0] wet_gain,
    input  logic [COEF_BITS-1:0] dry_gain,
    output logic                 overrun
);
    localparam int unsigned DEPTH  = 2 ** ADDR_BITS;
    localparam int unsigned FILL_W = ADDR_BITS + 1;
    localparam int unsigned PROD_W = DATA_BITS + COEF_BITS + 1;
    localparam int unsigned SUM_W  = PROD_W + 1;

    typedef enum logic {ST_IDLE, ST_MIX} state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rdata_q;
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [DATA_BITS-1:0] din_q, din_d;
    logic [COEF_BITS-1:0] fb_q, fb_d, wet_q, wet_d, dry_q, dry_d;
    logic                 mask_q, mask_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    logic                    accept_c;
    logic [ADDR_BITS-1:0]    d_eff_c, rd_addr_c;
    logic [DATA_BITS-1:0]    x_d_c, w_c, y_c;
    logic signed [SUM_W-1:0] w_sum_c, y_sum_c;

    // Full-precision signed gain product, floored by the Q1.8 shift.
    function automatic logic signed [PROD_W-1:0] scale(input logic [COEF_BITS-1:0] g,
                                                        input logic signed [DATA_BITS-1:0] x);
        logic signed [PROD_W-1:0] pg, px, p;
        pg = PROD_W'($signed({1'b0, g}));
        px = PROD_W'(x);
        p  = pg * px;
        return p >>> 8;
    endfunction

    assign d_eff_c   = (delay_len == '0) ? ADDR_BITS'(1) : delay_len;
    assign rd_addr_c = wr_ptr_q - d_eff_c;
    assign x_d_c     = mask_q ? '0 : rdata_q;

    always_comb begin
        w_sum_c = SUM_W'($signed(din_q)) + SUM_W'(scale(fb_q, $signed(x_d_c)));
        y_sum_c = SUM_W'(scale(dry_q, $signed(din_q))) + SUM_W'(scale(wet_q, $signed(x_d_c)));
    end

`ifdef FEEDBACK_ECHO_SAT_EN
    function automatic logic [DATA_BITS-1:0] sat(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] maxv, minv;
        maxv = $signed({{(SUM_W-DATA_BITS+1){1'b0}}, {(DATA_BITS-1){1'b1}}});
        minv = ~maxv;
        if (s > maxv)      return maxv[DATA_BITS-1:0];
        else if (s < minv) return minv[DATA_BITS-1:0];
        else               return s[DATA_BITS-1:0];
    endfunction

    assign w_c = sat(w_sum_c);
    assign y_c = sat(y_sum_c);
`else
    logic unused_hi_c;

    assign w_c         = w_sum_c[DATA_BITS-1:0];
    assign y_c         = y_sum_c[DATA_BITS-1:0];
    assign unused_hi_c = ^{w_sum_c[SUM_W-1:DATA_BITS], y_sum_c[SUM_W-1:DATA_BITS]};
`endif

    // Accept in IDLE; MIX writes feedback sample and emits the output.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        din_d     = din_q;
        fb_d      = fb_q;
        wet_d     = wet_q;
        dry_d     = dry_q;
        mask_d    = mask_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        accept_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    accept_c = 1'b1;
                    state_d  = ST_MIX;
                    din_d    = bus.din;
                    fb_d     = fb_gain;
                    wet_d    = wet_gain;
                    dry_d    = dry_gain;
                    mask_d   = fill_q < FILL_W'(d_eff_c);
                end
            end
            ST_MIX: begin
                if (bus.enable) overrun_d = 1'b1;
                state_d  = ST_IDLE;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + 1'b1;
                dout_d   = y_c;
                valid_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            din_q     <= '0;
            fb_q      <= '0;
            wet_q     <= '0;
            dry_q     <= '0;
            mask_q    <= 1'b1;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
            din_q     <= din_d;
            fb_q      <= fb_d;
            wet_q     <= wet_d;
            dry_q     <= dry_d;
            mask_q    <= mask_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Delay line storage is never reset; the fill mask hides stale entries.
    always_ff @(posedge clk) begin
        if (state_q == ST_MIX) mem[wr_ptr_q] <= w_c;
        if (accept_c)          rdata_q       <= mem[rd_addr_c];
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign overrun        = overrun_q;
endmodule

// File: doc/feedback_echo.md
FEEDBACK_ECHO -- requirements
Module: feedback_echo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16, signed sample width.
REQ-002 SHALL have parameter ADDR_BITS, default 10, delay buffer depth = 2^ADDR_BITS samples.
REQ-003 SHALL have parameter COEF_BITS, default 9, unsigned Q1.8 gain width (256 = unity).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  sample strobe, one din sample per asserted cycle.
REQ-007 SHALL have port din  input  DATA_BITS  signed input sample.
REQ-008 SHALL have port delay_len  input  ADDR_BITS  echo delay in samples, D.
REQ-009 SHALL have port fb_gain  input  COEF_BITS  feedback gain.
REQ-010 SHALL have port wet_gain  input  COEF_BITS  delayed-path output gain.
REQ-011 SHALL have port dry_gain  input  COEF_BITS  direct-path output gain.
REQ-012 SHALL have port dout  output  DATA_BITS  signed output sample, registered.
REQ-013 SHALL have port dout_valid  output  1  one-cycle pulse per produced dout.
REQ-014 SHALL have port overrun  output  1  sticky: a strobe was dropped.

Function
REQ-015 SHALL store samples in a circular buffer of 2^ADDR_BITS entries; write pointer advances by 1 per accepted sample, wrapping modulo depth.
REQ-016 SHALL read delayed sample x_d at (wr_ptr - D) mod depth; D = 0 SHALL be treated as D = 1.
REQ-017 SHALL pipeline: cycle N enable accepted (din, gains, D latched, buffer read issued); N+1 mix computed, buffer written; N+2 dout updated and dout_valid = 1 for exactly that cycle.
REQ-018 SHALL accept enable only when pipeline idle; an enable in cycle N+1 after an accepted strobe SHALL be dropped and set overrun = 1 until reset.
REQ-019 SHALL write w = SAT(din + ((fb_gain * x_d) >>> 8)) to the buffer (feedback path).
REQ-020 SHALL output y = SAT(((dry_gain * din) >>> 8) + ((wet_gain * x_d) >>> 8)).
REQ-021 SHALL perform products signed, full precision (DATA_BITS+COEF_BITS+1 bits), arithmetic right shift (floor toward minus infinity), sum with one guard bit before SAT.
REQ-022 SHALL keep a fill counter of writes since reset, saturating at depth; while fill count < D, x_d SHALL be forced to 0 regardless of buffer contents.
REQ-023 SHALL apply a changed delay_len or gain from the next accepted strobe; no output glitch other than an immediate tap jump.
REQ-024 SHALL hold dout between strobes; dout_valid = 0 when no result is emitted.
REQ-025 SHALL treat pointer wrap (wr_ptr from depth-1 to 0) with no gap or repeated sample.

Reset
REQ-026 SHALL on rst_n = 0, asynchronously clear dout = 0, dout_valid = 0, overrun = 0, wr_ptr = 0, fill count = 0, pipeline idle.
REQ-027 SHALL not require clearing buffer memory; stale contents SHALL be masked by REQ-022.
REQ-028 SHALL discard any in-flight sample when reset asserts mid-pipeline; no dout_valid for it after release.

Configuration
REQ-029 SHALL use macro FEEDBACK_ECHO_SAT_EN: defined -> SAT clamps to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1]; undefined -> SAT is two's-complement truncation to DATA_BITS (wrap).

Verification
REQ-030 SHALL cover impulse: D=4, dry=256, wet=256, fb=128, din=1000 then zeros, strobe every 4 cycles -> dout at samples 0,4,8,12 = 1000,1000,500,250, all others 0.
REQ-031 SHALL cover saturation: D=1, dry=wet=256, fb=0, din=30000 twice -> second dout = 32767 with FEEDBACK_ECHO_SAT_EN, -5536 without.
REQ-032 SHALL cover stale-memory masking: run 20 samples of 5000, pulse rst_n, D=8, feed zeros -> first 8 douts = 0.
REQ-033 SHALL cover overrun: enable asserted two consecutive cycles -> one dout_valid, overrun = 1 and held until rst_n low.
REQ-034 SHALL cover wrap: ADDR_BITS=3, D=7, ramp 1,2,3... for 20 samples, dry=0, wet=256, fb=0 -> dout at sample k = k-6 for k>=7 (sample index from 0, value k+1 input).
REQ-035 SHALL cover negative rounding: D=1, wet=128, dry=0, fb=0, din=-3 then 0 -> second dout = -2.
